// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall controller: load-use interlock, taken-branch flush and
// multi-cycle EX occupancy stall, with a saturating frozen-PC cycle counter.
module hazard_stall_controller #(
    parameter int unsigned MULTI_LATENCY = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic [4:0]       Rs_ID,
    input  logic [4:0]       Rt_ID,
    input  logic             UsesRs_ID,
    input  logic             UsesRt_ID,
    input  logic             MultiCycle_ID,
    input  logic             MemRead_EX,
    input  logic [4:0]       WriteReg_EX,
    input  logic             BranchTaken_EX,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             Busy,
    output logic [CNT_W-1:0] StallCount
);

    localparam int unsigned MCNT_W    = 4;
    localparam logic [MCNT_W-1:0] CNT_INIT = MCNT_W'(MULTI_LATENCY - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_MULTI = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [MCNT_W-1:0] r_cnt;
    logic [MCNT_W-1:0] w_cnt_nxt;
    logic              w_load_use;
    logic [CNT_W-1:0]  r_stall_cnt;

    // Loads into $0 never produce a value, so they cannot create a hazard.
    assign w_load_use = MemRead_EX && (WriteReg_EX != 5'd0) &&
                        ((UsesRs_ID && (Rs_ID == WriteReg_EX)) ||
                         (UsesRt_ID && (Rt_ID == WriteReg_EX)));

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (!BranchTaken_EX && !w_load_use && MultiCycle_ID) begin
                    w_state_nxt = S_MULTI;
                    w_cnt_nxt   = CNT_INIT;
                end
            end
            S_MULTI: begin
                w_cnt_nxt = r_cnt - MCNT_W'(1);
                if (r_cnt <= MCNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Hazard controls are combinational from state and live ID/EX inputs.
    always_comb begin
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        Busy        = 1'b0;
        if (reset) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (BranchTaken_EX) begin
                        IFID_Flush  = 1'b1;
                        IDEX_Bubble = 1'b1;
                    end else if (w_load_use) begin
                        PCWrite     = 1'b0;
                        IFID_Write  = 1'b0;
                        IDEX_Bubble = 1'b1;
                    end
                end
                S_MULTI: begin
                    PCWrite     = 1'b0;
                    IFID_Write  = 1'b0;
                    IDEX_Bubble = 1'b1;
                    Busy        = 1'b1;
                end
                default: begin
                    PCWrite = 1'b1;
                end
            endcase
        end
    end

    // Frozen-PC statistics; saturates rather than wrapping.
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (!PCWrite && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: each driven cycle pushes its
// expected controls, a negedge monitor pops and compares against the DUT.
module tb_hazard_stall_controller;

    localparam int unsigned CW = 4;

    logic          Clk = 1'b0;
    logic          reset;
    logic [4:0]    Rs_ID, Rt_ID, WriteReg_EX;
    logic          UsesRs_ID, UsesRt_ID, MultiCycle_ID, MemRead_EX, BranchTaken_EX;
    logic          PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, Busy;
    logic [CW-1:0] StallCount;

    typedef struct {
        string      tag;
        logic [4:0] ctl;     // {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, Busy}
        logic [3:0] cnt;
        logic       cnt_ok;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] exp_cnt  = 4'd0;
    logic       cnt_known = 1'b0;

    hazard_stall_controller #(.MULTI_LATENCY(4), .CNT_W(CW)) dut (
        .Clk(Clk), .reset(reset),
        .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
        .UsesRs_ID(UsesRs_ID), .UsesRt_ID(UsesRt_ID),
        .MultiCycle_ID(MultiCycle_ID), .MemRead_EX(MemRead_EX),
        .WriteReg_EX(WriteReg_EX), .BranchTaken_EX(BranchTaken_EX),
        .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
        .IDEX_Bubble(IDEX_Bubble), .Busy(Busy), .StallCount(StallCount)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs (called just after a rising edge).
    task automatic cyc(input string tag, input logic rst, input logic br,
                       input logic mr, input logic [4:0] wr,
                       input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt,
                       input logic mc, input logic [4:0] exp_ctl);
        exp_t e;
        reset = rst; BranchTaken_EX = br; MemRead_EX = mr; WriteReg_EX = wr;
        Rs_ID = rs; UsesRs_ID = urs; Rt_ID = rt; UsesRt_ID = urt; MultiCycle_ID = mc;
        e.tag = tag; e.ctl = exp_ctl; e.cnt = exp_cnt; e.cnt_ok = cnt_known;
        sb_q.push_back(e);
        @(posedge Clk);
        #1;
        if (rst) begin
            exp_cnt   = 4'd0;
            cnt_known = 1'b1;
        end else if (!exp_ctl[4] && exp_cnt != 4'hF) begin
            exp_cnt = exp_cnt + 4'd1;
        end
    endtask

    localparam logic [4:0] RST  = 5'b00110;
    localparam logic [4:0] IDL  = 5'b11000;
    localparam logic [4:0] LU   = 5'b00010;
    localparam logic [4:0] BR   = 5'b11110;
    localparam logic [4:0] MUL  = 5'b00011;

    always @(negedge Clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.tag, ".PCWrite"},     32'(PCWrite),     32'(e.ctl[4]));
            check({e.tag, ".IFID_Write"},  32'(IFID_Write),  32'(e.ctl[3]));
            check({e.tag, ".IFID_Flush"},  32'(IFID_Flush),  32'(e.ctl[2]));
            check({e.tag, ".IDEX_Bubble"}, 32'(IDEX_Bubble), 32'(e.ctl[1]));
            check({e.tag, ".Busy"},        32'(Busy),        32'(e.ctl[0]));
            if (e.cnt_ok) check({e.tag, ".StallCount"}, 32'(StallCount), 32'(e.cnt));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; BranchTaken_EX = 1'b0; MemRead_EX = 1'b0; WriteReg_EX = 5'd0;
        Rs_ID = 5'd0; Rt_ID = 5'd0; UsesRs_ID = 1'b0; UsesRt_ID = 1'b0; MultiCycle_ID = 1'b0;
        @(posedge Clk); #1;

        //        tag       rst br mr wr     rs     urs rt     urt mc  exp
        cyc("rst0",     1, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, 0, RST);
        cyc("rst1",     1, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, 0, RST);
        cyc("idle",     0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, 0, IDL);

        // Load-use through rt, then one released cycle
        cyc("lu_rt",    0, 0, 1, 5'd8,  5'd3,  1, 5'd8,  1, 0, LU);
        cyc("lu_after", 0, 0, 0, 5'd0,  5'd3,  1, 5'd8,  1, 0, IDL);
        cyc("lu_rs",    0, 0, 1, 5'd5,  5'd5,  1, 5'd9,  1, 0, LU);
        cyc("no_use",   0, 0, 1, 5'd8,  5'd1,  1, 5'd8,  0, 0, IDL);
        cyc("reg0",     0, 0, 1, 5'd0,  5'd0,  1, 5'd0,  1, 0, IDL);
        cyc("no_load",  0, 0, 0, 5'd8,  5'd8,  1, 5'd8,  1, 0, IDL);

        // Branch beats load-use and multi-cycle; no MULTI entry afterwards
        cyc("br_prio",  0, 1, 1, 5'd8,  5'd0,  0, 5'd8,  1, 1, BR);
        cyc("br_after", 0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, 0, IDL);
        cyc("lu_mc",    0, 0, 1, 5'd8,  5'd0,  0, 5'd8,  1, 1, LU);
        cyc("lu_mc2",   0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, 0, IDL);

        // Multi-cycle from a clean count; hazards in MULTI are ignored
        cyc("m_rst",    1, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, 0, RST);
        cyc("m_enter",  0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, 1, IDL);
        cyc("m1",       0, 1, 0, 5'd0,  5'd0,  0, 5'd0,  0, 1, MUL);
        cyc("m2",       0, 0, 1, 5'd8,  5'd0,  0, 5'd8,  1, 0, MUL);
        cyc("m3",       0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, 0, MUL);
        cyc("m_done",   0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, 0, IDL);
        cyc("m_idle",   0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, 0, IDL);

        // Back-to-back multi-cycle instructions
        for (int k = 0; k < 2; k++) begin
            cyc("b2b_enter", 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, IDL);
            for (int j = 0; j < 3; j++)
                cyc("b2b_m",  0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, MUL);
        end
        cyc("b2b_done", 0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, 0, IDL);

        // Reset in second MULTI cycle aborts the stall
        cyc("r_enter",  0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, 1, IDL);
        cyc("r_m1",     0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, 0, MUL);
        cyc("r_m2rst",  1, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, 0, RST);
        cyc("r_post",   0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, 0, IDL);
        cyc("r_post2",  0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, 0, IDL);

        // Twenty load-use stalls saturate the 4-bit counter at 15
        for (int k = 0; k < 20; k++)
            cyc("sat_lu", 0, 0, 1, 5'd12, 5'd12, 1, 5'd0, 0, 0, LU);
        cyc("sat_hold", 0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, 0, IDL);
        cyc("sat_rst",  1, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, 0, RST);
        cyc("sat_clr",  0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, 0, IDL);

        @(negedge Clk); #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 SHALL provide parameter MULTI_LATENCY, default 4, meaning the EX-stage occupancy in cycles of a multi-cycle instruction; legal range 2..15.
REQ-002 SHALL provide parameter CNT_W, default 16, meaning the width of the stall statistics counter.
REQ-003 Clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  is the reset; it SHALL be synchronous and active-high.
REQ-005 Rs_ID  input  5  is the rs field of the instruction in ID.
REQ-006 Rt_ID  input  5  is the rt field of the instruction in ID.
REQ-007 UsesRs_ID  input  1  is high when the ID instruction reads rs.
REQ-008 UsesRt_ID  input  1  is high when the ID instruction reads rt.
REQ-009 MultiCycle_ID  input  1  is high when the ID instruction needs a multi-cycle EX operation.
REQ-010 MemRead_EX  input  1  is high when the EX instruction is a load.
REQ-011 WriteReg_EX  input  5  is the selected destination register of the EX instruction.
REQ-012 BranchTaken_EX  input  1  is high when the EX instruction resolves a taken branch or jump.
REQ-013 PCWrite  output  1  enables the PC update.
REQ-014 IFID_Write  output  1  enables the IF/ID register load.
REQ-015 IFID_Flush  output  1  clears IF/ID to a NOP.
REQ-016 IDEX_Bubble  output  1  forces all ID/EX control inputs (RegWrite, MemWrite, MemRead, MemToReg, BHC) to 0.
REQ-017 Busy  output  1  is high while the multi-cycle stall is active.
REQ-018 StallCount  output  CNT_W  counts frozen-PC cycles.

Function
REQ-019 The block SHALL implement two states, IDLE and MULTI, plus a 4-bit down-counter cnt.
REQ-020 LoadUse SHALL be MemRead_EX & (WriteReg_EX != 0) & ((UsesRs_ID & Rs_ID == WriteReg_EX) | (UsesRt_ID & Rt_ID == WriteReg_EX)).
REQ-021 Hazard outputs SHALL be combinational from the state and the current inputs, with zero-cycle latency.
REQ-022 IDLE default: PCWrite=1, IFID_Write=1, IFID_Flush=0, IDEX_Bubble=0, Busy=0.
REQ-023 IDLE priority SHALL be BranchTaken_EX, then LoadUse, then MultiCycle_ID.
REQ-024 IDLE with BranchTaken_EX: IFID_Flush=1, IDEX_Bubble=1, PCWrite=1, IFID_Write=1; the state stays IDLE; LoadUse and MultiCycle_ID are ignored that cycle.
REQ-025 IDLE with LoadUse and no branch: PCWrite=0, IFID_Write=0, IDEX_Bubble=1 for exactly one cycle; the state stays IDLE.
REQ-026 IDLE with MultiCycle_ID and neither of the above: outputs are the IDLE default so the instruction enters EX; next state is MULTI; cnt loads MULTI_LATENCY-1.
REQ-027 MULTI: PCWrite=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=0, Busy=1; cnt decrements each cycle.
REQ-028 In MULTI, when cnt==1 the next state SHALL be IDLE, giving exactly MULTI_LATENCY-1 stall cycles.
REQ-029 In MULTI, BranchTaken_EX, LoadUse and MultiCycle_ID SHALL be ignored; the held ID instruction is re-evaluated in IDLE.
REQ-030 Back-to-back multi-cycle instructions SHALL re-enter MULTI on the first IDLE cycle after the previous stall.
REQ-031 StallCount SHALL increment on every cycle with PCWrite=0 and reset=0, and SHALL saturate at all-ones (no wrap).
REQ-032 A register write to $0 SHALL never cause a load-use stall.

Reset
REQ-033 While reset=1 the block SHALL drive PCWrite=0, IFID_Write=0, IFID_Flush=1, IDEX_Bubble=1, Busy=0.
REQ-034 On the first edge with reset=1 the block SHALL set state=IDLE, cnt=0 and StallCount=0.
REQ-035 Reset asserted during MULTI SHALL abort the stall; the block is in IDLE on the first cycle after reset deasserts.
REQ-036 Reset cycles SHALL NOT increment StallCount.

Verification
REQ-037 Load-use case: MemRead_EX=1, WriteReg_EX=8, Rt_ID=8, UsesRt_ID=1 -> exactly one cycle of PCWrite=0, IFID_Write=0, IDEX_Bubble=1; StallCount 0->1.
REQ-038 $0 case: the same stimulus with WriteReg_EX=0 -> no stall; PCWrite stays 1.
REQ-039 Branch priority: BranchTaken_EX=1 together with LoadUse true -> IFID_Flush=1, IDEX_Bubble=1, PCWrite=1; StallCount unchanged.
REQ-040 Multi-cycle, MULTI_LATENCY=4: MultiCycle_ID pulse -> Busy=1 and PCWrite=0 for exactly 3 cycles, then IDLE; StallCount=3.
REQ-041 Reset mid-operation: reset asserted in the 2nd MULTI cycle -> next cycle shows Busy=0 and StallCount=0; after reset deasserts, PCWrite=1.
REQ-042 Saturation: with CNT_W=4, run 20 load-use stalls -> StallCount holds at 15.
